// File: rtl/backup_mem_arbiter_pkg.sv
// Shared types for the two-client backup memory arbiter.
package backup_mem_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WDATA = 1'b1
  } state_t;

  localparam int CLIENT_ID_BITS = 1;

endpackage

// File: rtl/backup_mem_arbiter.sv
// Round-robin arbiter merging two request/write-data clients onto one memory port,
// with tag-based combinational routing of read responses back to the issuing client.
module backup_mem_arbiter
  import backup_mem_arbiter_pkg::*;
#(
  parameter int ADDR_BITS   = 26,
  parameter int TAG_BITS    = 5,
  parameter int DATA_BITS   = 128,
  parameter int DATA_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 c0_req_valid,
  output logic                 c0_req_ready,
  input  logic                 c0_req_rw,
  input  logic [ADDR_BITS-1:0] c0_req_addr,
  input  logic [TAG_BITS-1:0]  c0_req_tag,
  input  logic                 c0_req_data_valid,
  output logic                 c0_req_data_ready,
  input  logic [DATA_BITS-1:0] c0_req_data_bits,
  output logic                 c0_resp_valid,
  output logic [DATA_BITS-1:0] c0_resp_data,
  output logic [TAG_BITS-1:0]  c0_resp_tag,

  input  logic                 c1_req_valid,
  output logic                 c1_req_ready,
  input  logic                 c1_req_rw,
  input  logic [ADDR_BITS-1:0] c1_req_addr,
  input  logic [TAG_BITS-1:0]  c1_req_tag,
  input  logic                 c1_req_data_valid,
  output logic                 c1_req_data_ready,
  input  logic [DATA_BITS-1:0] c1_req_data_bits,
  output logic                 c1_resp_valid,
  output logic [DATA_BITS-1:0] c1_resp_data,
  output logic [TAG_BITS-1:0]  c1_resp_tag,

  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_rw,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  output logic [TAG_BITS:0]    mem_req_tag,
  output logic                 mem_req_data_valid,
  input  logic                 mem_req_data_ready,
  output logic [DATA_BITS-1:0] mem_req_data_bits,

  input  logic                 mem_resp_valid,
  input  logic [DATA_BITS-1:0] mem_resp_data,
  input  logic [TAG_BITS:0]    mem_resp_tag
);

  localparam int CNT_BITS = $clog2(DATA_CYCLES);
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(DATA_CYCLES - 1);

  state_t                    state_q, state_d;
  logic [CLIENT_ID_BITS-1:0] owner_q, owner_d;
  logic [CLIENT_ID_BITS-1:0] prio_q, prio_d;
  logic [CNT_BITS-1:0]       cnt_q, cnt_d;
  logic [CLIENT_ID_BITS-1:0] grant;
  logic                      idle;

  assign idle = (state_q == IDLE);

  // Contention goes to the pointer; otherwise whichever client is valid.
  always_comb begin
    grant = 1'b0;
    if (c0_req_valid && c1_req_valid) grant = prio_q;
    else if (c1_req_valid)            grant = 1'b1;
  end

  always_comb begin
    mem_req_valid = idle & (c0_req_valid | c1_req_valid);
    mem_req_rw    = grant[0] ? c1_req_rw   : c0_req_rw;
    mem_req_addr  = grant[0] ? c1_req_addr : c0_req_addr;
    mem_req_tag   = {grant, (grant[0] ? c1_req_tag : c0_req_tag)};
    c0_req_ready  = mem_req_ready & idle & (grant == 1'b0);
    c1_req_ready  = mem_req_ready & idle & (grant == 1'b1);
  end

  // Write data only flows from the burst owner; early data waits in the client.
  always_comb begin
    mem_req_data_valid = ~idle & (owner_q[0] ? c1_req_data_valid : c0_req_data_valid);
    mem_req_data_bits  = owner_q[0] ? c1_req_data_bits : c0_req_data_bits;
    c0_req_data_ready  = ~idle & (owner_q == 1'b0) & mem_req_data_ready;
    c1_req_data_ready  = ~idle & (owner_q == 1'b1) & mem_req_data_ready;
  end

  always_comb begin
    c0_resp_valid = mem_resp_valid & (mem_resp_tag[TAG_BITS] == 1'b0);
    c1_resp_valid = mem_resp_valid & (mem_resp_tag[TAG_BITS] == 1'b1);
    c0_resp_tag   = mem_resp_tag[TAG_BITS-1:0];
    c1_resp_tag   = mem_resp_tag[TAG_BITS-1:0];
    c0_resp_data  = mem_resp_data;
    c1_resp_data  = mem_resp_data;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_req_valid && mem_req_ready) begin
          prio_d = ~grant;
          if (mem_req_rw) begin
            state_d = WDATA;
            owner_d = grant;
            cnt_d   = '0;
          end
        end
      end
      WDATA: begin
        if (mem_req_data_valid && mem_req_data_ready) begin
          cnt_d = cnt_q + CNT_BITS'(1);
          if (cnt_q == LAST_BEAT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      prio_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_backup_mem_arbiter.sv
// Directed scoreboard bench for backup_mem_arbiter: stimulus queues expected
// memory requests, write beats and responses; a negedge monitor pops and compares.
module tb_backup_mem_arbiter;

  logic         clk;
  logic         reset;
  logic         c0_req_valid, c0_req_ready, c0_req_rw;
  logic [25:0]  c0_req_addr;
  logic [4:0]   c0_req_tag;
  logic         c0_req_data_valid, c0_req_data_ready;
  logic [127:0] c0_req_data_bits;
  logic         c0_resp_valid;
  logic [127:0] c0_resp_data;
  logic [4:0]   c0_resp_tag;
  logic         c1_req_valid, c1_req_ready, c1_req_rw;
  logic [25:0]  c1_req_addr;
  logic [4:0]   c1_req_tag;
  logic         c1_req_data_valid, c1_req_data_ready;
  logic [127:0] c1_req_data_bits;
  logic         c1_resp_valid;
  logic [127:0] c1_resp_data;
  logic [4:0]   c1_resp_tag;
  logic         mem_req_valid, mem_req_ready, mem_req_rw;
  logic [25:0]  mem_req_addr;
  logic [5:0]   mem_req_tag;
  logic         mem_req_data_valid, mem_req_data_ready;
  logic [127:0] mem_req_data_bits;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [5:0]   mem_resp_tag;

  typedef struct packed {
    logic        rw;
    logic [25:0] addr;
    logic [5:0]  tag;
  } req_t;

  typedef struct packed {
    logic         c0v;
    logic         c1v;
    logic [4:0]   tag;
    logic [127:0] data;
  } resp_t;

  req_t         req_q[$];
  logic [127:0] data_q[$];
  resp_t        resp_q[$];

  int vec_n  = 0;
  int miss_n = 0;

  logic [127:0] wb1 [4];
  logic [127:0] wb2 [4];

  backup_mem_arbiter #(
    .ADDR_BITS(26), .TAG_BITS(5), .DATA_BITS(128), .DATA_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_rw(c0_req_rw),
    .c0_req_addr(c0_req_addr), .c0_req_tag(c0_req_tag),
    .c0_req_data_valid(c0_req_data_valid), .c0_req_data_ready(c0_req_data_ready),
    .c0_req_data_bits(c0_req_data_bits),
    .c0_resp_valid(c0_resp_valid), .c0_resp_data(c0_resp_data), .c0_resp_tag(c0_resp_tag),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_rw(c1_req_rw),
    .c1_req_addr(c1_req_addr), .c1_req_tag(c1_req_tag),
    .c1_req_data_valid(c1_req_data_valid), .c1_req_data_ready(c1_req_data_ready),
    .c1_req_data_bits(c1_req_data_bits),
    .c1_resp_valid(c1_resp_valid), .c1_resp_data(c1_resp_data), .c1_resp_tag(c1_resp_tag),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake or response the DUT presents must match the next queued entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req_valid && mem_req_ready) begin
        if (req_q.size() == 0) chk("mem_req_unexpected", 128'({mem_req_rw, mem_req_addr, mem_req_tag}), 128'(0));
        else chk("mem_req", 128'({mem_req_rw, mem_req_addr, mem_req_tag}), 128'(req_q.pop_front()));
      end
      if (mem_req_data_valid && mem_req_data_ready) begin
        if (data_q.size() == 0) chk("wdata_unexpected", mem_req_data_bits, 128'hBAD);
        else chk("wdata", mem_req_data_bits, data_q.pop_front());
      end
      if (c0_resp_valid || c1_resp_valid) begin
        if (resp_q.size() == 0) begin
          chk("resp_unexpected", 128'({c0_resp_valid, c1_resp_valid}), 128'(0));
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          chk("resp_route", 128'({c0_resp_valid, c1_resp_valid, c0_resp_tag, c1_resp_tag}),
              128'({e.c0v, e.c1v, e.tag, e.tag}));
          chk("resp_data", 128'(c0_resp_data ^ c1_resp_data ^ e.data), e.data);
        end
      end
    end
  end

  initial begin
    wb1[0] = {4{32'hAAAA_0000}}; wb1[1] = {4{32'hBBBB_1111}};
    wb1[2] = {4{32'hCCCC_2222}}; wb1[3] = {4{32'hDDDD_3333}};
    wb2[0] = {4{32'hEEEE_4444}}; wb2[1] = {4{32'hFFFF_5555}};
    wb2[2] = {4{32'h1234_6666}}; wb2[3] = {4{32'h5678_7777}};

    reset = 1'b1;
    c0_req_valid = 0; c0_req_rw = 0; c0_req_addr = '0; c0_req_tag = '0;
    c0_req_data_valid = 0; c0_req_data_bits = '0;
    c1_req_valid = 0; c1_req_rw = 0; c1_req_addr = '0; c1_req_tag = '0;
    c1_req_data_valid = 0; c1_req_data_bits = '0;
    mem_req_ready = 1; mem_req_data_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0; mem_resp_tag = '0;
    cyc(); cyc();

    // During reset: request path acts as IDLE with prio 0, data path closed.
    c0_req_valid = 1; c0_req_addr = 26'h100; c0_req_tag = 5'd3;
    c1_req_valid = 1; c1_req_addr = 26'h200; c1_req_tag = 5'd7;
    c0_req_data_valid = 1; mem_req_data_ready = 1;
    @(negedge clk);
    chk("rst_mem_data_valid", 128'(mem_req_data_valid), 128'(0));
    chk("rst_c0_data_ready", 128'(c0_req_data_ready), 128'(0));
    chk("rst_c1_data_ready", 128'(c1_req_data_ready), 128'(0));
    chk("rst_c0_req_ready", 128'(c0_req_ready), 128'(1));
    chk("rst_c1_req_ready", 128'(c1_req_ready), 128'(0));
    chk("rst_mem_req_tag", 128'(mem_req_tag), 128'(6'b0_00011));

    // Simultaneous reads after reset: client 0 first, then client 1.
    cyc();
    reset = 0; c0_req_data_valid = 0; mem_req_data_ready = 0;
    req_q.push_back('{rw: 1'b0, addr: 26'h100, tag: 6'b0_00011});
    req_q.push_back('{rw: 1'b0, addr: 26'h200, tag: 6'b1_00111});
    @(negedge clk);
    chk("both_rd_c1_held", 128'(c1_req_ready), 128'(0));
    cyc(); c0_req_valid = 0;
    cyc(); c1_req_valid = 0;

    // Response routed to client 1.
    mem_resp_valid = 1; mem_resp_tag = 6'b1_00010; mem_resp_data = 128'hBEEF;
    resp_q.push_back('{c0v: 1'b0, c1v: 1'b1, tag: 5'd2, data: 128'hBEEF});
    cyc(); mem_resp_valid = 0;

    // Client 1 write burst with client 0 requesting during it; early data held off.
    c1_req_valid = 1; c1_req_rw = 1; c1_req_addr = 26'h40; c1_req_tag = 5'd1;
    c1_req_data_valid = 1; c1_req_data_bits = wb1[0]; mem_req_data_ready = 1;
    req_q.push_back('{rw: 1'b1, addr: 26'h40, tag: 6'b1_00001});
    for (int i = 0; i < 4; i++) data_q.push_back(wb1[i]);
    @(negedge clk);
    chk("early_data_held", 128'(c1_req_data_ready), 128'(0));
    cyc();
    c1_req_valid = 0; c1_req_rw = 0;
    c0_req_valid = 1; c0_req_rw = 0; c0_req_addr = 26'h80; c0_req_tag = 5'd4;
    req_q.push_back('{rw: 1'b0, addr: 26'h80, tag: 6'b0_00100});
    for (int i = 0; i < 4; i++) begin
      c1_req_data_bits = wb1[i];
      if (i == 1) begin
        mem_resp_valid = 1; mem_resp_tag = 6'b1_11111; mem_resp_data = 128'hCAFE;
        resp_q.push_back('{c0v: 1'b0, c1v: 1'b1, tag: 5'd31, data: 128'hCAFE});
      end
      @(negedge clk);
      chk("burst_c0_ready_low", 128'(c0_req_ready), 128'(0));
      chk("burst_mem_req_valid_low", 128'(mem_req_valid), 128'(0));
      cyc();
      mem_resp_valid = 0;
    end
    c1_req_data_valid = 0;
    @(negedge clk);
    chk("c0_grant_after_burst", 128'(c0_req_ready), 128'(1));
    cyc(); c0_req_valid = 0;

    // Client 0 write with toggling memory data_ready.
    c0_req_valid = 1; c0_req_rw = 1; c0_req_addr = 26'h10; c0_req_tag = 5'd9;
    c0_req_data_valid = 1; c0_req_data_bits = wb2[0]; mem_req_data_ready = 0;
    req_q.push_back('{rw: 1'b1, addr: 26'h10, tag: 6'b0_01001});
    for (int i = 0; i < 4; i++) data_q.push_back(wb2[i]);
    cyc();
    c0_req_valid = 0; c0_req_rw = 0;
    for (int k = 0; k < 7; k++) begin
      c0_req_data_bits = wb2[k/2];
      mem_req_data_ready = (k % 2 == 0);
      cyc();
    end
    c0_req_data_bits = 128'hDEAD; mem_req_data_ready = 1;
    @(negedge clk);
    chk("idle_after_4th_valid", 128'(mem_req_data_valid), 128'(0));
    chk("idle_after_4th_ready", 128'(c0_req_data_ready), 128'(0));
    cyc(); c0_req_data_valid = 0;

    // Reset two beats into a client 0 burst (prio is 1 going in).
    c0_req_valid = 1; c0_req_rw = 1; c0_req_addr = 26'h20; c0_req_tag = 5'd2;
    c0_req_data_valid = 1; c0_req_data_bits = wb1[2]; mem_req_data_ready = 1;
    req_q.push_back('{rw: 1'b1, addr: 26'h20, tag: 6'b0_00010});
    data_q.push_back(wb1[2]);
    data_q.push_back(wb1[3]);
    cyc(); c0_req_valid = 0; c0_req_rw = 0;
    cyc(); c0_req_data_bits = wb1[3];
    cyc(); c0_req_data_bits = 128'hDEAD; reset = 1;
    @(negedge clk);
    chk("rst_mid_data_valid", 128'(mem_req_data_valid), 128'(0));
    chk("rst_mid_data_ready", 128'(c0_req_data_ready), 128'(0));
    cyc();
    reset = 0; c0_req_data_valid = 0;
    c0_req_valid = 1; c0_req_addr = 26'h300; c0_req_tag = 5'd10;
    c1_req_valid = 1; c1_req_addr = 26'h304; c1_req_tag = 5'd1;
    mem_resp_valid = 1; mem_resp_tag = 6'b0_00101; mem_resp_data = 128'h1234;
    req_q.push_back('{rw: 1'b0, addr: 26'h300, tag: 6'b0_01010});
    req_q.push_back('{rw: 1'b0, addr: 26'h304, tag: 6'b1_00001});
    resp_q.push_back('{c0v: 1'b1, c1v: 1'b0, tag: 5'd5, data: 128'h1234});
    @(negedge clk);
    chk("post_rst_data_ready", 128'(c0_req_data_ready), 128'(0));
    chk("post_rst_prio0", 128'(c1_req_ready), 128'(0));
    cyc(); c0_req_valid = 0; mem_resp_valid = 0;
    cyc(); c1_req_valid = 0;
    repeat (3) cyc();

    chk("req_q_drained", 128'(req_q.size()), 128'(0));
    chk("data_q_drained", 128'(data_q.size()), 128'(0));
    chk("resp_q_drained", 128'(resp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule

// File: doc/backup_mem_arbiter.md
BACKUP_MEM_ARBITER -- requirements
Module: backup_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 26, request address width.
REQ-002 SHALL have parameter TAG_BITS, default 5, client tag width; the memory-side tag is TAG_BITS+1 bits wide.
REQ-003 SHALL have parameter DATA_BITS, default 128, data beat width.
REQ-004 SHALL have parameter DATA_CYCLES, default 4, beats per write burst (power of two, 2 or more).
REQ-005 SHALL have ports clk and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 cN_req_valid / cN_req_ready / cN_req_rw  in/out/in  1 each  client N request handshake and direction (1 = write), N = 0, 1.
REQ-009 cN_req_addr  in  ADDR_BITS  client N address; cN_req_tag  in  TAG_BITS  client N tag.
REQ-010 cN_req_data_valid / cN_req_data_ready  in/out  1  client N write-data handshake; cN_req_data_bits  in  DATA_BITS.
REQ-011 cN_resp_valid  out  1; cN_resp_data  out  DATA_BITS; cN_resp_tag  out  TAG_BITS  client N read response.
REQ-012 mem_req_valid/ready/rw  out/in/out  1; mem_req_addr  out  ADDR_BITS; mem_req_tag  out  TAG_BITS+1  memory request port.
REQ-013 mem_req_data_valid/ready  out/in  1; mem_req_data_bits  out  DATA_BITS  memory write-data port.
REQ-014 mem_resp_valid  in  1; mem_resp_data  in  DATA_BITS; mem_resp_tag  in  TAG_BITS+1  memory response (no backpressure).

Function
REQ-015 SHALL implement states IDLE and WDATA, plus registers owner (1 bit), beat counter (log2 DATA_CYCLES bits) and priority pointer prio (1 bit).
REQ-016 In IDLE, grant SHALL be combinational: if both clients are valid, the client equal to prio wins; otherwise the single valid client wins.
REQ-017 In IDLE, mem_req_valid SHALL be c0_req_valid OR c1_req_valid; rw and addr come from the granted client; mem_req_tag = {grant, granted tag}.
REQ-018 cN_req_ready SHALL be mem_req_ready AND IDLE AND grant==N; the non-granted client's ready SHALL be 0.
REQ-019 On an accepted request (mem_req_valid and mem_req_ready), prio SHALL be set to the other client.
REQ-020 An accepted write SHALL move the block to WDATA with owner=grant and counter=0; an accepted read SHALL leave it in IDLE.
REQ-021 In WDATA, mem_req_valid SHALL be 0 and both cN_req_ready SHALL be 0.
REQ-022 In WDATA, mem_req_data_valid/bits SHALL come from client owner; c(owner)_req_data_ready = mem_req_data_ready; the other client's data_ready SHALL be 0.
REQ-023 Each data handshake SHALL increment the counter; the handshake at counter==DATA_CYCLES-1 SHALL return the block to IDLE, with the counter wrapping to 0.
REQ-024 In IDLE, mem_req_data_valid and both cN_req_data_ready SHALL be 0; write data presented early is held off, not dropped.
REQ-025 Response routing SHALL be combinational: cN_resp_valid = mem_resp_valid AND mem_resp_tag[TAG_BITS]==N; cN_resp_tag = mem_resp_tag[TAG_BITS-1:0]; cN_resp_data = mem_resp_data to both clients.
REQ-026 Request and response paths SHALL add zero cycles of latency.
REQ-027 A response arriving in the same cycle as a request or data handshake SHALL be routed unaffected.

Reset
REQ-028 While reset is asserted, the block SHALL hold state=IDLE, owner=0, counter=0 and prio=0.
REQ-029 Reset asserted mid-WDATA SHALL abandon the burst with no further data_ready, because the memory is reset with the same signal.
REQ-030 Output values during reset: mem_req_data_valid=0 and cN_req_data_ready=0; the request path behaves as in IDLE with prio=0.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, WDATA) and the client-ID width constant (1).
REQ-032 The design SHALL be a single module with no sub-modules; the round-robin grant stays inline.

Verification
REQ-033 Both clients issue a read together after reset, with tags 3 and 7 -> client 0 is granted first with mem_req_tag=6'b0_00011; client 1 is granted next with 6'b1_00111.
REQ-034 Client 1 issues a write to addr 0x40 with beats A, B, C, D, while client 0 requests during the burst -> c0_req_ready=0 for 4 data handshakes; client 0 is granted in the cycle after beat D.
REQ-035 mem_resp with tag 6'b1_00010 and data 0xBEEF -> c1_resp_valid=1, c1_resp_tag=2, c0_resp_valid=0 in the same cycle.
REQ-036 mem_req_data_ready toggles 1,0,1,0,... during a write -> exactly 4 beats pass in order, and the block returns to IDLE after the 4th.
REQ-037 Reset is asserted after 2 of 4 write beats -> IDLE, data_ready=0 and prio=0 on the following cycle; a new read from client 0 is then accepted normally.
